// File: rtl/ternary_pe_mc_if.sv
// Bus bundle for ternary_pe_mc: sample input, upstream/downstream accumulator streams,
// status and FSM state for observation.
interface ternary_pe_mc_if #(
    parameter int A_W        = 3,
    parameter int W_W        = 3,
    parameter int NCH        = 2,
    parameter int ACC_DATA_W = 8
);
    localparam int ACC_POS    = A_W + W_W - 1;
    localparam int ACC_N      = NCH * ACC_POS;
    localparam int ACC_ADDR_W = $clog2(ACC_N);

    // Every stream (aw_*, acc_*_in, acc_*_out) transfers on the rising clk edge where
    // valid and ready are both high; the valid side holds its payload stable until then.
    logic [2*A_W-1:0]       a;
    logic [2*W_W*NCH-1:0]   w;
    logic                   aw_valid;
    logic                   eow;
    logic                   aw_ready;

    logic                   acc_valid_in;
    logic                   acc_ready_out;
    logic [ACC_ADDR_W-1:0]  acc_addr_in;
    logic [ACC_DATA_W-1:0]  acc_data_in;

    logic                   acc_valid_out;
    logic                   acc_ready_in;
    logic [ACC_ADDR_W-1:0]  acc_addr_out;
    logic [ACC_DATA_W-1:0]  acc_data_out;

    logic                   busy;
    logic [1:0]             comp_state;
    logic [1:0]             drain_state;

    modport slave (
        input  a, w, aw_valid, eow, acc_valid_in, acc_addr_in, acc_data_in, acc_ready_in,
        output aw_ready, acc_ready_out, acc_valid_out, acc_addr_out, acc_data_out, busy,
               comp_state, drain_state
    );

    modport master (
        output a, w, aw_valid, eow, acc_valid_in, acc_addr_in, acc_data_in, acc_ready_in,
        input  aw_ready, acc_ready_out, acc_valid_out, acc_addr_out, acc_data_out, busy,
               comp_state, drain_state
    );
endinterface

// File: rtl/ternary_pe_mc.sv
// Ternary multi-channel PE with double-buffered accumulator banks and a chained drain port.
// Optional macro TERNARY_PE_SAT_EN makes compute/receive additions saturate instead of wrap.
module ternary_pe_mc #(
    parameter int A_W        = 3,
    parameter int W_W        = 3,
    parameter int NCH        = 2,
    parameter int ACC_DATA_W = 8,
    parameter int HEAD       = 0
) (
    input logic         clk,
    input logic         rst,
    ternary_pe_mc_if.slave bus
);
    localparam int ACC_POS    = A_W + W_W - 1;
    localparam int ACC_N      = NCH * ACC_POS;
    localparam int ACC_ADDR_W = $clog2(ACC_N);
    localparam int I_W        = (A_W > 1) ? $clog2(A_W) : 1;
    localparam int J_W        = (W_W > 1) ? $clog2(W_W) : 1;
    localparam logic [ACC_ADDR_W-1:0] LAST_ADDR = ACC_ADDR_W'(ACC_N - 1);
    localparam logic [I_W-1:0]        I_LAST    = I_W'(A_W - 1);
    localparam logic [J_W-1:0]        J_LAST    = J_W'(W_W - 1);
    localparam logic [ACC_DATA_W-1:0] ONE       = ACC_DATA_W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT_SWAP = 2'd2} comp_t;
    typedef enum logic [1:0] {FREE = 2'd0, RECV = 2'd1, SEND = 2'd2} drain_t;

    comp_t  comp_state, comp_next;
    drain_t drain_state, drain_next;

    logic [2*A_W-1:0]      a_q;
    logic [2*W_W*NCH-1:0]  w_q;
    logic                  eow_q;
    logic [I_W-1:0]        i_idx;
    logic [J_W-1:0]        j_idx;

    // bank_sel is the compute bank; the other one belongs to the drain side.
    logic                      bank_sel;
    logic                      shadow;
    logic [1:0][ACC_N-1:0]     vld;
    logic [ACC_DATA_W-1:0]     mem [2][ACC_N];
    logic [ACC_ADDR_W-1:0]     recv_cnt;
    logic [ACC_ADDR_W-1:0]     send_addr;

    logic                      take, run_last, send_done, drain_free, swap;
    logic                      recv_take, recv_ok;
    logic [ACC_DATA_W-1:0]     recv_val, send_word;
    logic [NCH-1:0]            upd_en;
    logic [ACC_ADDR_W-1:0]     upd_idx [NCH];
    logic [ACC_DATA_W-1:0]     upd_val [NCH];

    function automatic logic [ACC_DATA_W-1:0] acc_add(input logic [ACC_DATA_W-1:0] x,
                                                      input logic [ACC_DATA_W-1:0] y);
`ifdef TERNARY_PE_SAT_EN
        logic [ACC_DATA_W:0] s;
        s = {x[ACC_DATA_W-1], x} + {y[ACC_DATA_W-1], y};
        if (s[ACC_DATA_W] != s[ACC_DATA_W-1])
            return s[ACC_DATA_W] ? {1'b1, {(ACC_DATA_W-1){1'b0}}} : {1'b0, {(ACC_DATA_W-1){1'b1}}};
        return s[ACC_DATA_W-1:0];
`else
        return x + y;
`endif
    endfunction

    assign shadow     = ~bank_sel;
    assign take       = bus.aw_valid && (comp_state == IDLE);
    assign run_last   = (comp_state == RUN) && (i_idx == I_LAST) && (j_idx == J_LAST);
    assign send_done  = (drain_state == SEND) && bus.acc_ready_in && (send_addr == LAST_ADDR);
    // Drain finishing in this very cycle counts as free so a pending swap is not delayed.
    assign drain_free = (drain_state == FREE) || send_done;
    assign swap       = drain_free && ((run_last && eow_q) || (comp_state == WAIT_SWAP));
    assign recv_take  = (drain_state == RECV) && bus.acc_valid_in;
    assign recv_ok    = recv_take && (bus.acc_addr_in <= LAST_ADDR);
    assign recv_val   = acc_add(vld[shadow][bus.acc_addr_in] ? mem[shadow][bus.acc_addr_in] : '0,
                                bus.acc_data_in);
    assign send_word  = vld[shadow][send_addr] ? mem[shadow][send_addr] : '0;

    always_comb begin
        comp_next = comp_state;
        case (comp_state)
            IDLE:      if (take) comp_next = RUN;
            RUN:       if (run_last) comp_next = (!eow_q || drain_free) ? IDLE : WAIT_SWAP;
            WAIT_SWAP: if (drain_free) comp_next = IDLE;
            default:   comp_next = IDLE;
        endcase
    end

    always_comb begin
        drain_next = drain_state;
        if (swap) begin
            drain_next = (HEAD != 0) ? SEND : RECV;
        end else begin
            case (drain_state)
                RECV:    if (recv_take && (recv_cnt == LAST_ADDR)) drain_next = SEND;
                SEND:    if (send_done) drain_next = FREE;
                default: drain_next = drain_state;
            endcase
        end
    end

    // One digit pair per RUN cycle, all channels at once; unwritten words read as zero.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            upd_idx[c] = ACC_ADDR_W'(c * ACC_POS + int'(i_idx) + int'(j_idx));
            upd_en[c]  = (comp_state == RUN) && a_q[2*int'(i_idx)+1]
                         && w_q[c*2*W_W + 2*int'(j_idx) + 1];
            upd_val[c] = acc_add(vld[bank_sel][upd_idx[c]] ? mem[bank_sel][upd_idx[c]] : '0,
                                 (a_q[2*int'(i_idx)] == w_q[c*2*W_W + 2*int'(j_idx)]) ? ONE : '1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            comp_state  <= IDLE;
            drain_state <= FREE;
            a_q         <= '0;
            w_q         <= '0;
            eow_q       <= 1'b0;
            i_idx       <= '0;
            j_idx       <= '0;
            bank_sel    <= 1'b0;
            vld         <= '0;
            recv_cnt    <= '0;
            send_addr   <= '0;
        end else begin
            comp_state  <= comp_next;
            drain_state <= drain_next;
            if (take) begin
                a_q   <= bus.a;
                w_q   <= bus.w;
                eow_q <= bus.eow;
                i_idx <= '0;
                j_idx <= '0;
            end else if (comp_state == RUN) begin
                if (j_idx == J_LAST) begin
                    j_idx <= '0;
                    i_idx <= (i_idx == I_LAST) ? '0 : i_idx + 1'b1;
                end else begin
                    j_idx <= j_idx + 1'b1;
                end
            end
            for (int c = 0; c < NCH; c++)
                if (upd_en[c]) vld[bank_sel][upd_idx[c]] <= 1'b1;
            if (recv_ok) vld[shadow][bus.acc_addr_in] <= 1'b1;
            if (recv_take) recv_cnt <= recv_cnt + 1'b1;
            if ((drain_state == SEND) && bus.acc_ready_in) send_addr <= send_addr + 1'b1;
            if (swap) begin
                bank_sel       <= ~bank_sel;
                vld[shadow]    <= '0;
                recv_cnt       <= '0;
                send_addr      <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++)
                if (upd_en[c]) mem[bank_sel][upd_idx[c]] <= upd_val[c];
            if (recv_ok) mem[shadow][bus.acc_addr_in] <= recv_val;
        end
    end

    assign bus.aw_ready      = (comp_state == IDLE);
    assign bus.acc_ready_out = (drain_state == RECV);
    assign bus.acc_valid_out = (drain_state == SEND);
    assign bus.acc_addr_out  = (drain_state == SEND) ? send_addr : '0;
    assign bus.acc_data_out  = (drain_state == SEND) ? send_word : '0;
    assign bus.busy          = (comp_state != IDLE) || (drain_state != FREE);
    assign bus.comp_state    = comp_state;
    assign bus.drain_state   = drain_state;
endmodule

// File: tb/tb_ternary_pe_mc.sv
// Scoreboard bench for ternary_pe_mc: head PE, chained PE and a 4-bit accumulator PE.
module tb_ternary_pe_mc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Scoreboard entries: {dut[1:0], addr[3:0], data[7:0]}.
    logic [13:0] exp_q[$];

    logic [5:0]  a_d [3];
    logic [11:0] w_d [3];
    logic        aw_valid_d [3];
    logic        eow_d [3];
    logic        rdy_d [3];
    logic        up_valid;
    logic [3:0]  up_addr;
    logic [7:0]  up_data;

    logic        aw_ready_o [3];
    logic        valid_o [3];
    logic        busy_o [3];
    logic [3:0]  addr_o [3];
    logic [7:0]  data_o [3];
    logic [1:0]  cst [3];
    logic [1:0]  dst [3];
    logic        ready_out_c;

    ternary_pe_mc_if #(.ACC_DATA_W(8)) bus_h ();
    ternary_pe_mc_if #(.ACC_DATA_W(8)) bus_c ();
    ternary_pe_mc_if #(.ACC_DATA_W(4)) bus_n ();

    ternary_pe_mc #(.HEAD(1))                   u_h (.clk(clk), .rst(rst), .bus(bus_h));
    ternary_pe_mc #(.HEAD(0))                   u_c (.clk(clk), .rst(rst), .bus(bus_c));
    ternary_pe_mc #(.HEAD(1), .ACC_DATA_W(4))   u_n (.clk(clk), .rst(rst), .bus(bus_n));

    assign bus_h.a = a_d[0];  assign bus_h.w = w_d[0];
    assign bus_h.aw_valid = aw_valid_d[0];  assign bus_h.eow = eow_d[0];
    assign bus_h.acc_ready_in = rdy_d[0];
    assign bus_h.acc_valid_in = 1'b0;  assign bus_h.acc_addr_in = '0;  assign bus_h.acc_data_in = '0;

    assign bus_c.a = a_d[1];  assign bus_c.w = w_d[1];
    assign bus_c.aw_valid = aw_valid_d[1];  assign bus_c.eow = eow_d[1];
    assign bus_c.acc_ready_in = rdy_d[1];
    assign bus_c.acc_valid_in = up_valid;  assign bus_c.acc_addr_in = up_addr;
    assign bus_c.acc_data_in = up_data;

    assign bus_n.a = a_d[2];  assign bus_n.w = w_d[2];
    assign bus_n.aw_valid = aw_valid_d[2];  assign bus_n.eow = eow_d[2];
    assign bus_n.acc_ready_in = rdy_d[2];
    assign bus_n.acc_valid_in = 1'b0;  assign bus_n.acc_addr_in = '0;  assign bus_n.acc_data_in = '0;

    assign aw_ready_o[0] = bus_h.aw_ready;  assign aw_ready_o[1] = bus_c.aw_ready;
    assign aw_ready_o[2] = bus_n.aw_ready;
    assign valid_o[0] = bus_h.acc_valid_out;  assign valid_o[1] = bus_c.acc_valid_out;
    assign valid_o[2] = bus_n.acc_valid_out;
    assign busy_o[0] = bus_h.busy;  assign busy_o[1] = bus_c.busy;  assign busy_o[2] = bus_n.busy;
    assign addr_o[0] = bus_h.acc_addr_out;  assign addr_o[1] = bus_c.acc_addr_out;
    assign addr_o[2] = bus_n.acc_addr_out;
    assign data_o[0] = bus_h.acc_data_out;  assign data_o[1] = bus_c.acc_data_out;
    assign data_o[2] = {4'h0, bus_n.acc_data_out};
    assign cst[0] = bus_h.comp_state;  assign cst[1] = bus_c.comp_state;
    assign cst[2] = bus_n.comp_state;
    assign dst[0] = bus_h.drain_state;  assign dst[1] = bus_c.drain_state;
    assign dst[2] = bus_n.drain_state;
    assign ready_out_c = bus_c.acc_ready_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_window(input int d, input logic [7:0] base,
                               input int p0, input logic [7:0] v0,
                               input int p1, input logic [7:0] v1,
                               input int p2, input logic [7:0] v2);
        for (int k = 0; k < 10; k++) begin
            logic [7:0] v;
            v = base;
            if (k == p0) v = v0;
            if (k == p1) v = v1;
            if (k == p2) v = v2;
            exp_q.push_back({2'(d), 4'(k), v});
        end
    endtask

    task automatic send_sample(input int d, input logic [5:0] a, input logic [11:0] w,
                               input logic e);
        int n;
        n = 0;
        @(negedge clk);
        a_d[d] = a;  w_d[d] = w;  eow_d[d] = e;  aw_valid_d[d] = 1'b1;
        while (!aw_ready_o[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!aw_ready_o[d]) begin
            checks++;  failures++;
            $display("FAIL sample_accept dut=%0d actual=timeout required=aw_ready", d);
        end
        @(posedge clk);
        #1;
        aw_valid_d[d] = 1'b0;  eow_d[d] = 1'b0;
    endtask

    task automatic send_up(input logic [3:0] addr, input logic [7:0] data);
        int n;
        n = 0;
        @(negedge clk);
        up_valid = 1'b1;  up_addr = addr;  up_data = data;
        while (!ready_out_c && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_out_c) begin
            checks++;  failures++;
            $display("FAIL upstream_accept actual=timeout required=acc_ready_out");
        end
        @(posedge clk);
        #1;
        up_valid = 1'b0;
    endtask

    task automatic set_rdy(input int d, input logic v);
        @(posedge clk);
        #1;
        rdy_d[d] = v;
    endtask

    task automatic wait_drained(input int d);
        int n;
        n = 0;
        while ((busy_o[d] || exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'({busy_o[d], exp_q.size() == 0}), 32'({1'b0, 1'b1}));
    endtask

    // Monitor: every accepted downstream word must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                if (valid_o[d] && rdy_d[d]) begin
                    if (exp_q.size() == 0) begin
                        checks++;  failures++;
                        $display("FAIL sent_word dut=%0d actual=%0h/%0h required=none",
                                 d, addr_o[d], data_o[d]);
                    end else begin
                        logic [13:0] e;
                        e = exp_q.pop_front();
                        check("sent_word", 32'({2'(d), addr_o[d], data_o[d]}), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sat0, sat5;
        int n;
        rst = 1'b0;
        up_valid = 1'b0;  up_addr = '0;  up_data = '0;
        for (int d = 0; d < 3; d++) begin
            a_d[d] = '0;  w_d[d] = '0;  aw_valid_d[d] = 1'b0;  eow_d[d] = 1'b0;  rdy_d[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset values.
        @(negedge clk);
        check("rst_aw_ready", 32'(aw_ready_o[0]), 32'd1);
        check("rst_valid_out", 32'(valid_o[0]), 32'd0);
        check("rst_addr_out", 32'(addr_o[0]), 32'd0);
        check("rst_data_out", 32'(data_o[0]), 32'd0);
        check("rst_busy", 32'(busy_o[0]), 32'd0);
        check("rst_ready_out", 32'(ready_out_c), 32'd0);
        check("rst_states", 32'({cst[0], dst[0]}), 32'd0);

        // Single window, head PE.
        push_window(0, 8'h00, 0, 8'h01, 5, 8'hFF, -1, 8'h00);
        send_sample(0, 6'b000010, 12'b000011_000010, 1'b1);
        @(negedge clk);
        check("run_busy_ready", 32'({busy_o[0], aw_ready_o[0], cst[0]}), 32'({1'b1, 1'b0, 2'd1}));
        wait_drained(0);

        // Same sample twice, eow only on the second.
        push_window(0, 8'h00, 0, 8'h02, 5, 8'hFE, -1, 8'h00);
        send_sample(0, 6'b000010, 12'b000011_000010, 1'b0);
        send_sample(0, 6'b000010, 12'b000011_000010, 1'b1);
        wait_drained(0);

        // Downstream stall for 5 cycles at the first SEND word.
        set_rdy(0, 1'b0);
        push_window(0, 8'h00, 0, 8'h01, 5, 8'hFF, -1, 8'h00);
        send_sample(0, 6'b000010, 12'b000011_000010, 1'b1);
        n = 0;
        while (!valid_o[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("stall_hold", 32'({valid_o[0], addr_o[0], data_o[0]}), 32'({1'b1, 4'd0, 8'h01}));
            @(negedge clk);
        end
        set_rdy(0, 1'b1);
        wait_drained(0);

        // Second window finishes while the first is still stalled downstream.
        set_rdy(0, 1'b0);
        push_window(0, 8'h00, 0, 8'h01, 5, 8'hFF, -1, 8'h00);
        send_sample(0, 6'b000010, 12'b000011_000010, 1'b1);
        send_sample(0, 6'b001000, 12'b110000_000010, 1'b1);
        repeat (12) @(negedge clk);
        check("wait_swap_hold", 32'({cst[0], aw_ready_o[0], dst[0], valid_o[0], addr_o[0]}),
              32'({2'd2, 1'b0, 2'd2, 1'b1, 4'd0}));
        push_window(0, 8'h00, 1, 8'h01, 8, 8'hFF, -1, 8'h00);
        set_rdy(0, 1'b1);
        n = 0;
        while (!(valid_o[0] && addr_o[0] == 4'd9) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("swap_same_cycle", 32'({valid_o[0], addr_o[0], cst[0], aw_ready_o[0]}),
              32'({1'b1, 4'd0, 2'd0, 1'b1}));
        wait_drained(0);

        // Reset in the middle of RUN discards the window.
        send_sample(0, 6'b000010, 12'b000011_000010, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset", 32'({busy_o[0], cst[0], dst[0], valid_o[0], aw_ready_o[0]}),
              32'({1'b0, 2'd0, 2'd0, 1'b0, 1'b1}));
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("mid_reset_idle", 32'({busy_o[0], valid_o[0]}), 32'd0);

        // Negative digits, zero-coded digits and a higher weight digit.
        push_window(0, 8'h00, 0, 8'h01, 5, 8'hFF, 7, 8'hFF);
        send_sample(0, 6'b010111, 12'b100010_000011, 1'b1);
        wait_drained(0);

        // Chained PE: upstream words are held off until RECV, then added in.
        push_window(1, 8'h03, 0, 8'h04, 5, 8'h02, -1, 8'h00);
        send_sample(1, 6'b000010, 12'b000011_000010, 1'b1);
        @(negedge clk);
        check("recv_not_ready_in_run", 32'(ready_out_c), 32'd0);
        for (int k = 0; k < 10; k++) send_up(4'(k), 8'h03);
        wait_drained(1);

        // 4-bit accumulator, nine accumulations of +1 / -1.
`ifdef TERNARY_PE_SAT_EN
        sat0 = 8'h07;  sat5 = 8'h08;
`else
        sat0 = 8'h09;  sat5 = 8'h07;
`endif
        push_window(2, 8'h00, 0, sat0, 5, sat5, -1, 8'h00);
        for (int k = 0; k < 9; k++) send_sample(2, 6'b000010, 12'b000011_000010, k == 8);
        wait_drained(2);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ternary_pe_mc.md
TERNARY_PE_MC -- requirements
Module: ternary_pe_mc

Interface
REQ-001 Parameter A_W, default 3: activation digits per sample.
REQ-002 Parameter W_W, default 3: weight digits per channel.
REQ-003 Parameter NCH, default 2: weight channels processed in parallel.
REQ-004 Parameter ACC_DATA_W, default 8: accumulator word width, two's complement.
REQ-005 Parameter HEAD, default 0: 1 = first PE in chain, no upstream data.
REQ-006 Local ACC_POS = A_W+W_W-1; ACC_N = NCH*ACC_POS; ACC_ADDR_W = $clog2(ACC_N).
REQ-007 Clock and reset: reset rst, synchronous, active-low; clock clk.
REQ-008 Port list, one per line:
- a  in  2*A_W  activation digits.
- w  in  2*W_W*NCH  weights; channel c occupies slice c*2*W_W.
- aw_valid  in  1  sample valid.
- eow  in  1  last sample of window; qualified by aw_valid.
- aw_ready  out  1  sample accepted when high with aw_valid.
- acc_valid_in  in  1  upstream word valid.
- acc_ready_out  out  1  PE accepts upstream word.
- acc_addr_in  in  ACC_ADDR_W  upstream word address.
- acc_data_in  in  ACC_DATA_W  upstream word.
- acc_valid_out  out  1  downstream word valid.
- acc_ready_in  in  1  downstream accepts word.
- acc_addr_out  out  ACC_ADDR_W  downstream word address.
- acc_data_out  out  ACC_DATA_W  downstream word.
- busy  out  1  compute or drain in progress.

Function
REQ-009 Digit encoding: 2 bits {nz,sign}, digit 0 at bits [1:0]; 2'b10 = +1, 2'b11 = -1, 2'b0x = 0.
REQ-010 Compute FSM states: IDLE, RUN, WAIT_SWAP; aw_ready = 1 only in IDLE.
REQ-011 Handshake: a, w and eow are captured on aw_valid&aw_ready; the FSM then moves IDLE->RUN.
REQ-012 RUN lasts exactly A_W*W_W cycles and processes one digit pair (i,j) per cycle, i outer, j inner, all channels in parallel.
REQ-013 Per pair, if both digits are nz, active bank word c*ACC_POS+(i+j) += +1 when signs are equal, else -1; zero pairs leave the word unchanged.
REQ-014 Active bank words read as 0 until first written after a swap, via per-word valid bits with no clear cycle.
REQ-015 End of RUN without eow: the FSM returns to IDLE.
REQ-016 End of RUN with eow: if the shadow bank is FREE, banks swap and the FSM goes to IDLE; otherwise it goes to WAIT_SWAP until the shadow bank becomes FREE, then swaps.
REQ-017 Drain FSM states for the shadow bank: FREE, RECV, SEND.
REQ-018 Swap moves the drain FSM to RECV, or to SEND when HEAD=1.
REQ-019 RECV: acc_ready_out = 1; each accepted word adds acc_data_in into shadow[acc_addr_in]; after ACC_N accepted words the FSM moves to SEND.
REQ-020 SEND: addresses 0..ACC_N-1 are sent in order; acc_data_out = shadow[acc_addr_out]; acc_valid_out is held with address and data stable until acc_ready_in.
REQ-021 The last accepted SEND word moves the drain FSM to FREE.
REQ-022 acc_data_out = 0 whenever acc_valid_out = 0.
REQ-023 Upstream words arriving outside RECV are not accepted (acc_ready_out = 0).
REQ-024 Compute and drain run concurrently on opposite banks.
REQ-025 A swap request in the same cycle the drain reaches FREE swaps in that cycle.
REQ-026 busy = (compute FSM != IDLE) | (drain FSM != FREE).
REQ-027 Default arithmetic wraps modulo 2^ACC_DATA_W.

Reset
REQ-028 With rst low at a clock edge: both FSMs go to IDLE/FREE, all bank valid bits clear, and in-flight work is discarded.
REQ-029 Output values in reset: aw_ready = 1 from the first cycle after reset; acc_valid_out, acc_ready_out, acc_addr_out, acc_data_out and busy = 0.

Configuration
REQ-030 Macro TERNARY_PE_SAT_EN defined: compute and receive additions saturate to [-2^(ACC_DATA_W-1), 2^(ACC_DATA_W-1)-1].
REQ-031 Macro TERNARY_PE_SAT_EN undefined: compute and receive additions wrap; no saturation logic is instantiated.

Verification
REQ-032 HEAD=1, defaults: a=6'b000010, w=12'b000011_000010, eow=1 -> after 9 RUN cycles, 10 words are sent: addr0=8'h01, addr5=8'hFF, all others 0.
REQ-033 Same sample twice, eow only on the second -> addr0=8'h02, addr5=8'hFE.
REQ-034 acc_ready_in held low 5 cycles during SEND -> acc_valid_out stays 1, and addr and data stay constant; no word is skipped or duplicated.
REQ-035 HEAD=0, upstream sends 10 words of 8'h03 after the REQ-032 sample -> addr0=8'h04, addr5=8'h02, others 8'h03.
REQ-036 ACC_DATA_W=4, 9 samples of REQ-032, eow on the last -> addr0=4'h7 with TERNARY_PE_SAT_EN; addr0=4'h9 (-7) without.
REQ-037 A second eow window completes while downstream is stalled -> FSM holds WAIT_SWAP, aw_ready=0 until the last word is accepted, then swaps in that cycle.
